// File: rtl/part_74s299_if.sv
// -----------------------------------------------------------------------------
// part_74s299_if
//   This interface groups the mode, serial and output-enable controls of one
//   74S299 chip, together with its two always-driven serial outputs.
//   The clock, the clear and the eight shared three-state I/O pins are not in
//   here. They stay as plain ports on the chip model, so that a board netlist
//   can wire each pin directly to its net.
//
//   Signals (direction seen from the chip):
//     S0, S1       in   mode select, {S1,S0}: 00 hold, 01 shr, 10 shl, 11 load
//     DS0          in   serial in for shift-right (enters bit 0)
//     DS7          in   serial in for shift-left  (enters bit 7)
//     OE1_N, OE2_N in   active-low output enables for the IO pins
//     Q0, Q7       out  register bits 0 and 7, always driven
// -----------------------------------------------------------------------------
interface part_74s299_if;
   logic S0;
   logic S1;
   logic DS0;
   logic DS7;
   logic OE1_N;
   logic OE2_N;
   logic Q0;
   logic Q7;

   // chip side
   modport slave (
      input  S0, S1, DS0, DS7, OE1_N, OE2_N,
      output Q0, Q7
   );

   // board / driver side
   modport master (
      output S0, S1, DS0, DS7, OE1_N, OE2_N,
      input  Q0, Q7
   );
endinterface

// File: rtl/part_74s299.sv
// -----------------------------------------------------------------------------
// part_74s299
//   This is a zero-delay behavioural model of the 74S299, an 8-bit universal
//   shift/storage register whose eight parallel I/O pins are shared and
//   three-state. Use one instance per physical chip.
//
//   Ports:
//     CLK        in     rising-edge shift/load clock
//     CLR_N      in     asynchronous active-low clear (R <= 0 at once)
//     bus        slave  mode/serial/OE controls and the Q0/Q7 serial outputs
//     IO0..IO7   inout  shared parallel pins; IO0 = bit 0 (pin A), IO7 = bit 7 (pin H)
//
//   Behaviour:
//     * Modes {S1,S0} are sampled on the rising edge of CLK:
//         00 hold, 01 shift right (DS0 -> bit 0), 10 shift left (DS7 -> bit 7),
//         11 parallel load from the IO pins.
//     * An IO pin drives R[n] only when both OEs are low and the mode is not
//       load. In load mode the pins are always released, so the external source
//       can drive them.
//     * Q0 and Q7 follow R[0] and R[7] at all times.
// -----------------------------------------------------------------------------
module part_74s299 (
   input  logic          CLK,
   input  logic          CLR_N,
   part_74s299_if.slave  bus,
   inout  wire           IO0,
   inout  wire           IO1,
   inout  wire           IO2,
   inout  wire           IO3,
   inout  wire           IO4,
   inout  wire           IO5,
   inout  wire           IO6,
   inout  wire           IO7
);

   typedef enum logic [1:0] {
      MODE_HOLD = 2'b00,
      MODE_SHR  = 2'b01,
      MODE_SHL  = 2'b10,
      MODE_LOAD = 2'b11
   } mode_e;

   logic [7:0] r;
   logic [7:0] pin_in;
   logic       drive_en;
   mode_e      mode;

   assign mode = mode_e'({bus.S1, bus.S0});

   // The load path samples whatever the pins resolve to at the edge. If a pin
   // is x or z, that value passes straight into R. It is deliberately not
   // cleaned to 0, so that a floating bus stays visible downstream.
   assign pin_in = {IO7, IO6, IO5, IO4, IO3, IO2, IO1, IO0};

   // ---------------------------------------------------------------------------
   // Register. The clear is asynchronous and wins over any coincident edge.
   // While CLR_N is held low, clock edges have no effect.
   // ---------------------------------------------------------------------------
   always_ff @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N) begin
         r <= 8'h00;
      end else begin
         case (mode)
            MODE_SHR:  r <= {r[6:0], bus.DS0};
            MODE_SHL:  r <= {bus.DS7, r[7:1]};
            MODE_LOAD: r <= pin_in;
            default:   r <= r;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Pin drive. The drive enable is purely combinational. Changes to the OE
   // inputs or the mode between edges move only the pins and never touch R.
   // ---------------------------------------------------------------------------
   assign drive_en = !bus.OE1_N && !bus.OE2_N && (mode != MODE_LOAD);

   assign IO0 = drive_en ? r[0] : 1'bz;
   assign IO1 = drive_en ? r[1] : 1'bz;
   assign IO2 = drive_en ? r[2] : 1'bz;
   assign IO3 = drive_en ? r[3] : 1'bz;
   assign IO4 = drive_en ? r[4] : 1'bz;
   assign IO5 = drive_en ? r[5] : 1'bz;
   assign IO6 = drive_en ? r[6] : 1'bz;
   assign IO7 = drive_en ? r[7] : 1'bz;

   // The serial outputs ignore both the OE inputs and the mode.
   assign bus.Q0 = r[0];
   assign bus.Q7 = r[7];

endmodule

// File: tb/tb_part_74s299.sv
module tb_part_74s299;

   logic       CLK;
   logic       CLR_N;
   logic       tb_en;
   logic [7:0] tb_drv;
   int         n_cmp;
   int         n_err;

   wire IO0, IO1, IO2, IO3, IO4, IO5, IO6, IO7;
   wire [7:0] io_bus = {IO7, IO6, IO5, IO4, IO3, IO2, IO1, IO0};

   // bench-side drivers on the shared pins
   assign IO0 = tb_en ? tb_drv[0] : 1'bz;
   assign IO1 = tb_en ? tb_drv[1] : 1'bz;
   assign IO2 = tb_en ? tb_drv[2] : 1'bz;
   assign IO3 = tb_en ? tb_drv[3] : 1'bz;
   assign IO4 = tb_en ? tb_drv[4] : 1'bz;
   assign IO5 = tb_en ? tb_drv[5] : 1'bz;
   assign IO6 = tb_en ? tb_drv[6] : 1'bz;
   assign IO7 = tb_en ? tb_drv[7] : 1'bz;

   part_74s299_if bus ();

   part_74s299 dut (
      .CLK   (CLK),
      .CLR_N (CLR_N),
      .bus   (bus),
      .IO0   (IO0),
      .IO1   (IO1),
      .IO2   (IO2),
      .IO3   (IO3),
      .IO4   (IO4),
      .IO5   (IO5),
      .IO6   (IO6),
      .IO7   (IO7)
   );

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // one full clock: rising edge, then the falling edge, then settle
   task automatic tick();
      #5 CLK = 1'b1;
      #5 CLK = 1'b0;
      #1;
   endtask

   task automatic set_mode(input logic [1:0] m);
      bus.S1 = m[1];
      bus.S0 = m[0];
   endtask

   task automatic load(input logic [7:0] v);
      set_mode(2'b11);
      tb_drv = v;
      tb_en  = 1'b1;
      tick();
      tb_en  = 1'b0;
   endtask

   // Check that the DUT has released the pins. The bench drives the complement
   // of the register contents, and only a released bus reads back that value.
   task automatic chk_released(input string tag, input logic [7:0] rval);
      tb_drv = ~rval;
      tb_en  = 1'b1;
      #1;
      chk(tag, io_bus, ~rval);
      tb_en  = 1'b0;
      #1;
   endtask

   initial begin
      logic [7:0] shr_exp;
      n_cmp     = 0;
      n_err     = 0;
      CLK       = 1'b0;
      CLR_N     = 1'b0;
      tb_en     = 1'b0;
      tb_drv    = 8'h00;
      bus.DS0   = 1'b0;
      bus.DS7   = 1'b0;
      bus.OE1_N = 1'b1;
      bus.OE2_N = 1'b1;

      // reset: edges in load mode with FF on the pins are ignored
      set_mode(2'b11);
      tb_drv = 8'hFF;
      tb_en  = 1'b1;
      tick();
      tick();
      chk("rst_q0", {7'd0, bus.Q0}, 8'h00);
      chk("rst_q7", {7'd0, bus.Q7}, 8'h00);
      tb_en = 1'b0;
      set_mode(2'b00);
      bus.OE1_N = 1'b0;
      bus.OE2_N = 1'b0;
      #1;
      chk("rst_io", io_bus, 8'h00);

      // load and read back
      CLR_N = 1'b1;
      #2;
      load(8'hA5);
      chk("ld_q7_at_edge", {7'd0, bus.Q7}, 8'h01);
      set_mode(2'b00);
      #1;
      chk("ld_io", io_bus, 8'hA5);
      chk("ld_q0", {7'd0, bus.Q0}, 8'h01);
      tick();
      chk("hold_io", io_bus, 8'hA5);

      // shift-right serialise: Q7 gives 1,0,1,0,0,1,0,1 across the load and 7 shifts
      shr_exp = 8'hA5;
      set_mode(2'b01);
      bus.DS0 = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         tick();
         chk($sformatf("shr_q7_%0d", k), {7'd0, bus.Q7}, {7'd0, shr_exp[7-k]});
      end
      tick();
      chk("shr_final", io_bus, 8'h00);

      // shift-left with fill: 01 -> 80 -> C0 -> E0
      load(8'h01);
      set_mode(2'b10);
      bus.DS7 = 1'b1;
      tick();
      chk("shl_1", io_bus, 8'h80);
      tick();
      tick();
      chk("shl_3", io_bus, 8'hE0);
      chk("shl_q0", {7'd0, bus.Q0}, 8'h00);
      chk("shl_q7", {7'd0, bus.Q7}, 8'h01);
      bus.DS7 = 1'b0;

      // output enables and the load-mode release
      load(8'h3C);
      set_mode(2'b00);
      bus.OE1_N = 1'b1;
      chk_released("oe1_off", 8'h3C);
      bus.OE1_N = 1'b0;
      bus.OE2_N = 1'b1;
      chk_released("oe2_off", 8'h3C);
      bus.OE2_N = 1'b0;
      set_mode(2'b11);
      chk_released("load_mode_rel", 8'h3C);
      set_mode(2'b00);
      #1;
      chk("oe_on_io", io_bus, 8'h3C);
      chk("oe_q0", {7'd0, bus.Q0}, 8'h00);
      chk("oe_q7", {7'd0, bus.Q7}, 8'h00);

      // clear during shift: FF -> shr x3 -> F8, async clear, then one shift with DS0=1
      load(8'hFF);
      set_mode(2'b01);
      bus.DS0 = 1'b0;
      tick();
      tick();
      tick();
      chk("clr_pre", io_bus, 8'hF8);
      CLR_N = 1'b0;
      #1;
      chk("clr_imm_io", io_bus, 8'h00);
      chk("clr_imm_q7", {7'd0, bus.Q7}, 8'h00);
      CLR_N = 1'b1;
      bus.DS0 = 1'b1;
      #1;
      tick();
      chk("clr_post", io_bus, 8'h01);
      chk("clr_post_q0", {7'd0, bus.Q0}, 8'h01);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
